// File: rtl/keypad_pkg.sv
// Shared constants, state/result encodings and the row/column to key-code map
// for the keypad event scanner.
package keypad_pkg;

   localparam logic [3:0] KEY_STAR  = 4'd10;
   localparam logic [3:0] KEY_HASH  = 4'd11;

   localparam logic [2:0] COL_LEFT  = 3'b001;
   localparam logic [2:0] COL_MID   = 3'b010;
   localparam logic [2:0] COL_RIGHT = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_CHK,
      ST_PRESSED,
      ST_RELEASE_CHK
   } db_state_e;

   typedef enum logic [1:0] {
      FR_NONE,
      FR_SINGLE,
      FR_MULTI
   } frame_res_e;

   // Rows 0..2 carry the digit grid; row 3 is '*', '0', '#'.
   function automatic logic [3:0] key_code_of(input logic [1:0] col_idx,
                                              input logic [1:0] row_idx);
      logic [3:0] code;
      if (row_idx == 2'd3) begin
         case (col_idx)
            2'd0:    code = KEY_STAR;
            2'd1:    code = 4'd0;
            default: code = KEY_HASH;
         endcase
      end else begin
         code = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_event_scanner_if.sv
// Keypad pins plus the event handshake towards the game FSM.
interface keypad_event_scanner_if;
   logic [3:0] key_row;
   logic [2:0] key_col;
   logic       key_valid;
   logic       key_ready;
   logic [3:0] key_code;
   logic       key_held;
   logic       key_drop;

   modport master (
      input  key_row, key_ready,
      output key_col, key_valid, key_code, key_held, key_drop
   );

   modport slave (
      output key_row, key_ready,
      input  key_col, key_valid, key_code, key_held, key_drop
   );
endinterface

// File: rtl/keypad_col_scan.sv
// Column prescaler/rotation and per-frame accumulation of active row bits.
// Frame result is combinational on the cycle frame_end is high.
module keypad_col_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 12500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_sync,
   output logic [2:0] key_col,
   output logic       frame_end,
   output logic       frame_none,
   output logic       frame_multi,
   output logic [3:0] frame_code
);
   localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] div_q, div_d;
   logic [2:0]    col_q, col_d;
   logic [1:0]    hits_q, hits_d;
   logic [3:0]    code_q, code_d;
   logic          slot_end;
   logic [1:0]    col_idx;
   logic [2:0]    row_hits;
   logic [3:0]    row_code;
   logic [2:0]    sum;
   logic [3:0]    row_code_g [4];

   assign slot_end = (div_q == LAST);

   always_comb begin
      case (col_q)
         COL_MID:   col_idx = 2'd1;
         COL_RIGHT: col_idx = 2'd2;
         default:   col_idx = 2'd0;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_row
         assign row_code_g[gi] = key_code_of(col_idx, 2'(gi));
      end
   endgenerate

   always_comb begin
      row_hits = '0;
      row_code = '0;
      for (int r = 3; r >= 0; r--) begin
         if (row_sync[r]) begin
            row_hits = row_hits + 3'd1;
            row_code = row_code_g[r];
         end
      end
   end

   // Hit count saturates at 2: anything beyond one key is ghosting anyway.
   assign sum         = {1'b0, hits_q} + row_hits;
   assign frame_end   = slot_end && (col_q == COL_RIGHT);
   assign frame_none  = (sum == 3'd0);
   assign frame_multi = (sum >= 3'd2);
   assign frame_code  = (row_hits == 3'd1) ? row_code : code_q;
   assign key_col     = col_q;

   always_comb begin
      div_d  = slot_end ? '0 : div_q + CW'(1);
      col_d  = col_q;
      hits_d = hits_q;
      code_d = code_q;
      if (slot_end) begin
         case (col_q)
            COL_LEFT: col_d = COL_MID;
            COL_MID:  col_d = COL_RIGHT;
            default:  col_d = COL_LEFT;
         endcase
         if (col_q == COL_RIGHT) begin
            hits_d = '0;
            code_d = '0;
         end else begin
            hits_d = frame_multi ? 2'd2 : sum[1:0];
            code_d = frame_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q  <= '0;
         col_q  <= COL_LEFT;
         hits_q <= '0;
         code_q <= '0;
      end else begin
         div_q  <= div_d;
         col_q  <= col_d;
         hits_q <= hits_d;
         code_q <= code_d;
      end
   end

endmodule

// File: rtl/keypad_event_scanner.sv
// Keypad scanner top: row synchroniser, frame debouncer and one-entry event buffer.
// Optional KEYPAD_AUTOREPEAT_EN re-emits a held key every REPEAT_FRAMES frames.
module keypad_event_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 12500,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_FRAMES  = 250
) (
   input  logic                          clk,
   input  logic                          rst,
   keypad_event_scanner_if.master        kif
);
   localparam int DCW = $clog2(DEBOUNCE_SCANS + 1);

   logic [3:0]     sync1_q, sync2_q;
   logic           frame_end, frame_none, frame_multi;
   logic [3:0]     frame_code;
   frame_res_e     fres;
   db_state_e      state_q, state_d;
   logic [3:0]     cand_q, cand_d;
   logic [DCW-1:0] dcnt_q, dcnt_d;
   logic           emit_q, emit_d;
   logic           valid_q, valid_d, drop_q, drop_d, take;
   logic [3:0]     out_code_q, out_code_d;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_FRAMES + 1);
   logic [RW-1:0] rep_q, rep_d;
   logic          rep_due;
   assign rep_due = (int'(rep_q) + 1 >= REPEAT_FRAMES);
`else
   logic unused_repeat_frames;
   assign unused_repeat_frames = ^REPEAT_FRAMES;
`endif

   keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
      .clk         (clk),
      .rst         (rst),
      .row_sync    (sync2_q),
      .key_col     (kif.key_col),
      .frame_end   (frame_end),
      .frame_none  (frame_none),
      .frame_multi (frame_multi),
      .frame_code  (frame_code)
   );

   assign fres = frame_none ? FR_NONE : (frame_multi ? FR_MULTI : FR_SINGLE);

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      dcnt_d  = dcnt_q;
      emit_d  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_d   = (state_q == ST_PRESSED || state_q == ST_RELEASE_CHK) ? rep_q : '0;
`endif
      if (frame_end) begin
         case (state_q)
            ST_IDLE: begin
               if (fres == FR_SINGLE) begin
                  cand_d = frame_code;
                  dcnt_d = DCW'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     emit_d  = 1'b1;
                     state_d = ST_PRESSED;
                  end else begin
                     state_d = ST_PRESS_CHK;
                  end
               end
            end
            ST_PRESS_CHK: begin
               if (fres == FR_SINGLE && frame_code == cand_q) begin
                  dcnt_d = dcnt_q + DCW'(1);
                  if (int'(dcnt_q) + 1 >= DEBOUNCE_SCANS) begin
                     emit_d  = 1'b1;
                     state_d = ST_PRESSED;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PRESSED: begin
               if (fres == FR_NONE) begin
                  dcnt_d  = DCW'(1);
                  state_d = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE_CHK;
               end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                  if (rep_due) begin
                     emit_d = 1'b1;
                     rep_d  = '0;
                  end else begin
                     rep_d  = rep_q + RW'(1);
                  end
`endif
               end
            end
            default: begin
               // A bounce during release returns to PRESSED without a new event.
               if (fres == FR_NONE) begin
                  dcnt_d = dcnt_q + DCW'(1);
                  if (int'(dcnt_q) + 1 >= DEBOUNCE_SCANS) state_d = ST_IDLE;
               end else begin
                  state_d = ST_PRESSED;
               end
            end
         endcase
      end
   end

   // cand_q cannot change the cycle after an emit, so it is the event code.
   always_comb begin
      take       = valid_q & kif.key_ready;
      valid_d    = valid_q;
      out_code_d = out_code_q;
      drop_d     = 1'b0;
      if (emit_q) begin
         if (!valid_q || take) begin
            valid_d    = 1'b1;
            out_code_d = cand_q;
         end else begin
            drop_d     = 1'b1;
         end
      end else if (take) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         state_q    <= ST_IDLE;
         cand_q     <= '0;
         dcnt_q     <= '0;
         emit_q     <= 1'b0;
         valid_q    <= 1'b0;
         drop_q     <= 1'b0;
         out_code_q <= '0;
      end else begin
         sync1_q    <= kif.key_row;
         sync2_q    <= sync1_q;
         state_q    <= state_d;
         cand_q     <= cand_d;
         dcnt_q     <= dcnt_d;
         emit_q     <= emit_d;
         valid_q    <= valid_d;
         drop_q     <= drop_d;
         out_code_q <= out_code_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rep_q <= '0;
      else      rep_q <= rep_d;
   end
`endif

   assign kif.key_valid = valid_q;
   assign kif.key_code  = out_code_q;
   assign kif.key_drop  = drop_q;
   assign kif.key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_CHK);

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Randomised keypad stimulus checked every cycle against a frame-level model,
// plus directed scenarios with literal expectations.
module tb_keypad_event_scanner;

   localparam int SD = 4;
   localparam int DS = 2;
   localparam int RF = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] pressed = '0;
   int          tests = 0;
   int          fails = 0;

   keypad_event_scanner_if kif();

   keypad_event_scanner #(
      .SCAN_DIV       (SD),
      .DEBOUNCE_SCANS (DS),
      .REPEAT_FRAMES  (RF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif)
   );

   always #5 clk = ~clk;

   function automatic int key_of(input int c, input int r);
      case (r)
         0:       return c + 1;
         1:       return c + 4;
         2:       return c + 7;
         default: return (c == 0) ? 10 : ((c == 1) ? 0 : 11);
      endcase
   endfunction

   function automatic logic [11:0] key_bit(input int k);
      logic [11:0] b;
      b = '0;
      b[k] = 1'b1;
      return b;
   endfunction

   // Physical keypad: a pressed key connects its column drive to its row.
   function automatic logic [3:0] rows_for(input logic [2:0] col, input logic [11:0] p);
      logic [3:0] r;
      r = '0;
      for (int c = 0; c < 3; c++)
         if (col[c])
            for (int k = 0; k < 4; k++)
               if (p[key_of(c, k)]) r[k] = 1'b1;
      return r;
   endfunction

   always begin
      @(posedge clk);
      #2;
      kif.key_row = rows_for(kif.key_col, pressed);
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          n;
   logic [3:0]  hist [4];
   logic [3:0]  fr_rows [3];
   bit          m_held, m_pend, m_vld, m_drop;
   int          m_cand, m_run, m_rel, m_rep, m_pcode;
   logic [3:0]  m_code;

   task automatic model_accept();
      m_held  = 1'b1;
      m_rel   = 0;
      m_rep   = 0;
      m_pend  = 1'b1;
      m_pcode = m_cand;
   endtask

   task automatic frame_step();
      int  nb;
      int  code;
      bit  single;
      nb   = 0;
      code = 0;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 4; r++)
            if (fr_rows[c][r]) begin
               nb++;
               code = key_of(c, r);
            end
      single = (nb == 1);
      if (!m_held) begin
         if (m_run > 0) begin
            if (single && code == m_cand) begin
               m_run++;
               if (m_run >= DS) model_accept();
            end else begin
               m_run = 0;
            end
         end else if (single) begin
            m_cand = code;
            m_run  = 1;
            if (DS == 1) model_accept();
         end
      end else if (nb == 0) begin
         m_rel++;
         if (m_rel >= DS) begin
            m_held = 1'b0;
            m_run  = 0;
            m_rel  = 0;
         end
      end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
         if (m_rel == 0) begin
            m_rep++;
            if (m_rep >= RF) begin
               m_rep   = 0;
               m_pend  = 1'b1;
               m_pcode = m_cand;
            end
         end
`endif
         m_rel = 0;
      end
   endtask

   always @(posedge clk or negedge rst) begin
      bit          take;
      logic [3:0]  seen;
      int          col;
      if (!rst) begin
         n = 0;
         for (int i = 0; i < 4; i++) hist[i] = '0;
         for (int i = 0; i < 3; i++) fr_rows[i] = '0;
         m_held = 0; m_pend = 0; m_vld = 0; m_drop = 0;
         m_cand = 0; m_run = 0; m_rel = 0; m_rep = 0; m_pcode = 0;
         m_code = '0;
      end else begin
         n++;
         take   = m_vld && kif.key_ready;
         m_drop = 1'b0;
         if (m_pend) begin
            if (!m_vld || take) begin
               m_vld  = 1'b1;
               m_code = 4'(m_pcode);
            end else begin
               m_drop = 1'b1;
            end
            m_pend = 1'b0;
         end else if (take) begin
            m_vld = 1'b0;
         end
         // Row seen by the scanner is the pin value from two edges earlier.
         seen = (n >= 3) ? hist[(n - 2) % 4] : 4'd0;
         hist[n % 4] = kif.key_row;
         if (n % SD == 0) begin
            col = (n / SD - 1) % 3;
            fr_rows[col] = seen;
            if (col == 2) frame_step();
         end
      end
   end

   always @(negedge clk) begin
      check("key_col",   int'(kif.key_col),   1 << ((n / SD) % 3));
      check("key_valid", int'(kif.key_valid), int'(m_vld));
      check("key_code",  int'(kif.key_code),  int'(m_code));
      check("key_held",  int'(kif.key_held),  int'(m_held));
      check("key_drop",  int'(kif.key_drop),  int'(m_drop));
   end

   // ---------------- stimulus ----------------
   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (kif.key_valid) ok = 1'b1;
      end
   endtask

   initial begin
      bit ok;
      int drops;
      int events;
      int bad;
      int len;
      kif.key_row   = '0;
      kif.key_ready = 1'b0;

      // Reset values and column rotation
      repeat (3) @(negedge clk);
      check("rst_col",   int'(kif.key_col), 1);
      check("rst_valid", int'(kif.key_valid), 0);
      check("rst_code",  int'(kif.key_code), 0);
      check("rst_held",  int'(kif.key_held), 0);
      check("rst_drop",  int'(kif.key_drop), 0);
      rst = 1'b1;
      repeat (4) @(posedge clk); #1;
      check("col_after_4", int'(kif.key_col), 2);
      repeat (4) @(posedge clk); #1;
      check("col_after_8", int'(kif.key_col), 4);
      repeat (4) @(posedge clk); #1;
      check("col_after_12", int'(kif.key_col), 1);

      // Single press of key 5, consumer not ready
      @(negedge clk);
      pressed = key_bit(5);
      wait_valid(100, ok);
      check("t2_valid_seen", int'(ok), 1);
      check("t2_code", int'(kif.key_code), 5);
      check("t2_model_code", int'(m_code), 5);
      check("t2_held", int'(kif.key_held), 1);
      repeat (30) @(negedge clk);
      check("t2_valid_hold", int'(kif.key_valid), 1);
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;
      check("t2_valid_cleared", int'(kif.key_valid), 0);
`ifndef KEYPAD_AUTOREPEAT_EN
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         check("t2_no_second_event", int'(kif.key_valid), 0);
      end
`endif
      pressed = '0;
      repeat (60) @(negedge clk);
      check("t2_released", int'(kif.key_held), 0);
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;

      // Bounce: key 5 visible for exactly one frame
      @(negedge clk);
      pressed = key_bit(5);
      for (int i = 0; i < 72; i++) begin
         if (i == 12) pressed = '0;
         @(negedge clk);
         check("t3_no_valid", int'(kif.key_valid), 0);
         check("t3_no_held", int'(kif.key_held), 0);
      end

      // Ghosting: keys 1 and 3 together
      pressed = key_bit(1) | key_bit(3);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         check("t4_no_valid", int'(kif.key_valid), 0);
         check("t4_no_held", int'(kif.key_held), 0);
      end
      pressed = '0;
      repeat (24) @(negedge clk);

      // Drop on full buffer
      pressed = key_bit(1);
      wait_valid(100, ok);
      check("t5_first_valid", int'(ok), 1);
      check("t5_first_code", int'(kif.key_code), 1);
      pressed = '0;
      repeat (36) @(negedge clk);
      pressed = key_bit(11);
      drops = 0;
      for (int i = 0; i < 84; i++) begin
         if (i == 48) pressed = '0;
         @(negedge clk);
         if (kif.key_drop) drops++;
      end
      check("t5_drop_count", drops, 1);
      check("t5_code_kept", int'(kif.key_code), 1);
      check("t5_valid_kept", int'(kif.key_valid), 1);
      kif.key_ready = 1'b1;
      @(negedge clk);
      kif.key_ready = 1'b0;
      check("t5_valid_cleared", int'(kif.key_valid), 0);

`ifdef KEYPAD_AUTOREPEAT_EN
      // Auto-repeat of key 9 with an always-ready consumer
      kif.key_ready = 1'b1;
      pressed = key_bit(9);
      events = 0;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (kif.key_valid) begin
            events++;
            if (kif.key_code != 4'd9) bad++;
         end
      end
      check("t6_events_at_least_3", int'(events >= 3), 1);
      check("t6_bad_codes", bad, 0);
      pressed = '0;
      repeat (48) @(negedge clk);
      kif.key_ready = 1'b0;
`endif

      // Randomised traffic against the model
      for (int s = 0; s < 90; s++) begin
         case ($urandom_range(0, 3))
            0:       pressed = '0;
            3:       pressed = key_bit($urandom_range(0, 11)) | key_bit($urandom_range(0, 11));
            default: pressed = key_bit($urandom_range(0, 11));
         endcase
         len = $urandom_range(4, 48);
         for (int i = 0; i < len; i++) begin
            @(negedge clk);
            kif.key_ready = ($urandom_range(0, 3) == 0);
         end
         if (s == 45) begin
            @(posedge clk);
            #3 rst = 1'b0;
            #1;
            check("arst_col", int'(kif.key_col), 1);
            check("arst_valid", int'(kif.key_valid), 0);
            check("arst_held", int'(kif.key_held), 0);
            check("arst_code", int'(kif.key_code), 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
         end
      end

      pressed = '0;
      repeat (60) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_event_scanner.md
# keypad_event_scanner

Upstream stage of the tic-tac-toe game logic: drives the 3-column keypad scan, synchronises and debounces the 4 row lines, and delivers each clean key press to the game FSM as a single event. Events are held until the consumer takes them, so board updates no longer have to sample a raw, level-held `key_data`. The block replaces ad-hoc scanning with a counted, frame-based debouncer.

## Interface
- `SCAN_DIV`, 12500, clk cycles per column slot (≥2); 12500 gives 2 kHz column rate at 25 MHz.
- `DEBOUNCE_SCANS`, 4, consecutive identical full frames required to accept a press or a release (≥1).
- `REPEAT_FRAMES`, 250, frames between auto-repeat events (used only with `KEYPAD_AUTOREPEAT_EN`).
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-low reset.
- `key_row` in 4: raw row lines, bit0 = top row; asynchronous to `clk`.
- `key_col` out 3: one-hot column drive, 001 = left column.
- `key_valid` out 1: event available.
- `key_ready` in 1: consumer accepts the event when `key_valid`&`key_ready`.
- `key_code` out 4: 1–9 = digits, 0 = key 0, 10 = `*`, 11 = `#`.
- `key_held` out 1: a debounced key is currently down.
- `key_drop` out 1: one-cycle pulse when an accepted press was lost because the buffer was full.

## Operation
- `key_row` passes through a 2-flop synchroniser before any use.
- Prescaler counts 0..`SCAN_DIV`-1. The synchronised row is sampled on the last count of each slot. On the same edge `key_col` rotates 001→010→100→001.
- Frame = 3 slots, ending at the sample of column 100.
- Row→code mapping:
  - col 001, rows 0–3: 1, 4, 7, 10.
  - col 010, rows 0–3: 2, 5, 8, 0.
  - col 100, rows 0–3: 3, 6, 9, 11.
- Frame result:
  - NONE: zero active bits in the frame.
  - SINGLE(code): exactly one active bit.
  - MULTI: two or more active bits; treated as ghosting.
- Debounce FSM. It updates only at frame end; `cnt` saturates at `DEBOUNCE_SCANS`.
  - IDLE:
    - SINGLE(c) → cand=c, cnt=1. If `DEBOUNCE_SCANS`=1, emit and go to PRESSED; otherwise go to PRESS_CHK.
    - NONE/MULTI → stay in IDLE.
  - PRESS_CHK:
    - SINGLE(cand) → cnt+1. On reaching `DEBOUNCE_SCANS`: emit(cand) and go to PRESSED.
    - Any other result → IDLE.
  - PRESSED:
    - NONE → RELEASE_CHK, cnt=1. If `DEBOUNCE_SCANS`=1, go to IDLE instead.
    - Otherwise stay in PRESSED.
  - RELEASE_CHK:
    - NONE → cnt+1. On reaching `DEBOUNCE_SCANS` → IDLE.
    - SINGLE/MULTI → PRESSED. No new event is produced.
- `key_held` = 1 in PRESSED and RELEASE_CHK.
- Output buffer, one entry. On emit:
  - If buffer empty, or `key_valid`&`key_ready` in the same cycle: load `key_code`, `key_valid`=1.
  - Otherwise: `key_drop` pulses, and `key_code`/`key_valid` are unchanged.
- `key_valid` clears the cycle after a handshake when there is no simultaneous load. `key_code` holds its last value after the handshake.

## Timing
- Reset values: `key_col`=001, `key_valid`=0, `key_code`=0, `key_held`=0, `key_drop`=0, prescaler=0, FSM=IDLE.
- Frame length = 3·`SCAN_DIV` cycles. A press stable from a frame start is emitted after `DEBOUNCE_SCANS` frames.
- `key_valid` rises 1 cycle after the frame-end sample edge, i.e. registered emit.
- Row-to-sample delay is 2 cycles (synchroniser). The row must be stable for the last 3 cycles of a slot.
- When `rst` is asserted mid-operation, all state clears asynchronously and any pending event is discarded. Scanning restarts at column 001 on the first clk after release.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - While in PRESSED, a frame counter re-emits cand every `REPEAT_FRAMES` frames.
  - The counter resets on entry to PRESSED and is held through RELEASE_CHK.
  - Repeats obey the same drop rule as normal presses.
- Macro undefined: exactly one event per press; `REPEAT_FRAMES` is ignored and no counter logic is built.

## Structure
- `keypad_pkg`:
  - Code constants `KEY_STAR`=10 and `KEY_HASH`=11.
  - Column one-hot constants.
  - FSM state enum (IDLE, PRESS_CHK, PRESSED, RELEASE_CHK).
  - Frame-result encoding.
- Sub-module `keypad_col_scan`: prescaler, column rotation and frame accumulation. Outputs `frame_end`, `frame_none`, `frame_multi`, `frame_code`.
- Top level contains the synchroniser, debounce FSM and output buffer.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=2.
1. Reset and scan rotation: hold `rst`=0 → `key_col`=001, all other outputs 0. Release `rst` → `key_col` goes 010 after 4 clks, 100 after 8, and 001 after 12.
2. Single press with handshake: drive `key_row`=0010 whenever `key_col`=010 (key 5), with `key_ready`=0 → after 2 frames `key_valid`=1, `key_code`=5, `key_held`=1, and `key_valid` stays high. Pulse `key_ready` → `key_valid`=0 the next cycle, and no second event occurs while the key stays held.
3. Bounce rejection: key 5 present for exactly 1 frame, then released → no `key_valid` and `key_held` stays 0.
4. Ghost rejection: key 1 (col 001, row 0001) and key 3 (col 100, row 0001) held together for 5 frames → no event and `key_held`=0.
5. Drop on full buffer: key 1 accepted with `key_ready`=0, then released (2 frames) and `#` pressed (col 100, row 1000) → `key_drop` pulses once, `key_code` stays 1.
6. Auto-repeat, with `KEYPAD_AUTOREPEAT_EN` and `REPEAT_FRAMES`=3: hold key 9 with `key_ready`=1 → a first event, then one further event with code 9 every 3 frames until release.
